// File: rtl/irq_ctrl_if.sv
// Register bus between the bridge address decode and irq_ctrl.
//   sel    : select from the bridge decode
//   addr   : register offset, bits [3:2] decode the register
//   we     : write enable
//   byteen : byte enables, only byteen[0] qualifies a write
//   wdata  : write data
//   rdata  : read data, driven combinationally by the slave
interface irq_ctrl_if;
    logic        sel;
    logic [3:0]  addr;
    logic        we;
    logic [3:0]  byteen;
    logic [31:0] wdata;
    logic [31:0] rdata;

    modport master (output sel, addr, we, byteen, wdata, input rdata);
    modport slave  (input sel, addr, we, byteen, wdata, output rdata);
endinterface

// File: rtl/irq_ctrl.sv
// Priority interrupt controller with mask, edge/level select, pending
// and in-service tracking, and optional nesting of higher-priority sources.
// Optional build macro IRQ_CTRL_SYNC2_EN inserts a 2-flop synchronizer on src.
// Ports:
//   clk    : clock, rising edge
//   reset  : asynchronous active-low reset
//   src    : raw interrupt lines, bit 0 highest priority
//   bus    : register bus (slave side), rdata combinational
//   irq    : interrupt request to the CPU (from registers only)
//   hwint  : PEND & MASK, zero-extended to 6 bits
//   ack    : handler-entry pulse
//   eoi    : handler-return pulse
module irq_ctrl #(
    parameter int unsigned NSRC     = 6,
    parameter int unsigned ISR_NEST = 1
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    irq_ctrl_if.slave       bus,
    output logic            irq,
    output logic [5:0]      hwint,
    input  logic            ack,
    input  logic            eoi
);

    localparam int unsigned IDW = 3;
    localparam int unsigned DW  = 32;
    localparam int unsigned HW  = 6;

    localparam logic [1:0] A_MASK = 2'd0;
    localparam logic [1:0] A_EDGE = 2'd1;
    localparam logic [1:0] A_PEND = 2'd2;
    localparam logic [1:0] A_VEC  = 2'd3;

    logic [NSRC-1:0] r_mask;
    logic [NSRC-1:0] r_edge;
    logic [NSRC-1:0] r_pend;
    logic [NSRC-1:0] r_isr;
    logic [NSRC-1:0] r_src_d;

    logic [NSRC-1:0] w_src_s;
    logic [NSRC-1:0] w_wdata_n;
    logic            w_wr;
    logic [NSRC-1:0] w_elig;
    logic            w_win_vld;
    logic [IDW-1:0]  w_win_id;
    logic [NSRC-1:0] w_win_oh;
    logic            w_isr_any;
    logic [IDW-1:0]  w_isr_lo;
    logic [NSRC-1:0] w_isr_lo_oh;
    logic            w_nest_ok;
    logic            w_ack_ok;
    logic [NSRC-1:0] w_isr_after_eoi;
    logic [NSRC-1:0] w_isr_n;
    logic [NSRC-1:0] w_rise;
    logic [NSRC-1:0] w_w1c;
    logic [NSRC-1:0] w_ack_clr;
    logic [NSRC-1:0] w_pend_edge;
    logic [NSRC-1:0] w_pend_n;
    logic            w_unused;

    // Source sampling point: synchronized or direct
`ifdef IRQ_CTRL_SYNC2_EN
    logic [NSRC-1:0] r_sync1;
    logic [NSRC-1:0] r_sync2;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= src;
            r_sync2 <= r_sync1;
        end
    end

    assign w_src_s = r_sync2;
`else
    assign w_src_s = src;
`endif

    assign w_wr      = bus.sel & bus.we & bus.byteen[0];
    assign w_wdata_n = bus.wdata[NSRC-1:0];
    assign w_unused  = ^{bus.addr[1:0], bus.byteen[3:1], bus.wdata[DW-1:NSRC]};

    assign w_elig = r_pend & r_mask & ~r_isr;

    // Lowest-index eligible source and lowest in-service source
    always_comb begin
        w_win_vld = 1'b0;
        w_win_id  = '0;
        w_isr_any = 1'b0;
        w_isr_lo  = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (w_elig[i]) begin
                w_win_vld = 1'b1;
                w_win_id  = IDW'(i);
            end
            if (r_isr[i]) begin
                w_isr_any = 1'b1;
                w_isr_lo  = IDW'(i);
            end
        end
    end

    assign w_win_oh    = NSRC'(1) << w_win_id;
    assign w_isr_lo_oh = w_isr_any ? (NSRC'(1) << w_isr_lo) : '0;

    // A winner preempts only when strictly higher priority than the active handler
    assign w_nest_ok = (ISR_NEST != 0) && (w_win_id < w_isr_lo);
    assign irq       = w_win_vld & (~w_isr_any | w_nest_ok);
    assign w_ack_ok  = ack & irq;

    // eoi retires the current handler before ack records the new one
    assign w_isr_after_eoi = eoi ? (r_isr & ~w_isr_lo_oh) : r_isr;
    assign w_isr_n         = w_ack_ok ? (w_isr_after_eoi | w_win_oh) : w_isr_after_eoi;

    // Edge bits: a new rising edge beats any clear in the same cycle
    assign w_rise      = w_src_s & ~r_src_d;
    assign w_w1c       = (w_wr && (bus.addr[3:2] == A_PEND)) ? w_wdata_n : '0;
    assign w_ack_clr   = w_ack_ok ? w_win_oh : '0;
    assign w_pend_edge = w_rise | (r_pend & ~(w_w1c | w_ack_clr));
    assign w_pend_n    = (r_edge & w_pend_edge) | (~r_edge & w_src_s);

    // Register state
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_mask  <= '0;
            r_edge  <= '0;
            r_pend  <= '0;
            r_isr   <= '0;
            r_src_d <= '0;
        end else begin
            if (w_wr && (bus.addr[3:2] == A_MASK)) begin
                r_mask <= w_wdata_n;
            end
            if (w_wr && (bus.addr[3:2] == A_EDGE)) begin
                r_edge <= w_wdata_n;
            end
            r_pend  <= w_pend_n;
            r_isr   <= w_isr_n;
            r_src_d <= w_src_s;
        end
    end

    // Read mux, zero when not selected
    always_comb begin
        bus.rdata = '0;
        if (bus.sel) begin
            case (bus.addr[3:2])
                A_MASK:  bus.rdata = DW'(r_mask);
                A_EDGE:  bus.rdata = DW'(r_edge);
                A_PEND:  bus.rdata = DW'(r_pend);
                A_VEC:   bus.rdata = {w_win_vld, {(DW - 1 - IDW){1'b0}}, w_win_id};
                default: bus.rdata = '0;
            endcase
        end
    end

    assign hwint = HW'(r_pend & r_mask);

endmodule
